// File: rtl/flt2int_pkg.sv
// -----------------------------------------------------------------------------
// flt2int_pkg
//   Shared types and constants for the half-precision to sign-magnitude
//   integer converter: controller state encoding, exponent bias, saturation
//   magnitude, default data-memory addresses and internal datapath widths.
// -----------------------------------------------------------------------------
package flt2int_pkg;

   // Controller sequence: two byte reads, decode, iterative shift, two byte
   // writes, then park in DONE until the next reset.
   typedef enum logic [2:0] {
      RD_HI  = 3'd0,
      RD_LO  = 3'd1,
      DECODE = 3'd2,
      SHIFT  = 3'd3,
      WR_HI  = 3'd4,
      WR_LO  = 3'd5,
      DONE   = 3'd6
   } state_t;

   // Half-precision format
   localparam int BIAS   = 15;
   localparam int FRAC_W = 10;   // fraction width; e == FRAC_W means no shift
   localparam int MAX_E  = 14;   // largest exponent whose result fits 15 bits

   // Datapath widths
   localparam int MAG_W  = 26;   // magnitude shift register
   localparam int CNT_W  = 4;    // shift count, at most FRAC_W

   localparam logic [14:0] SAT_MAG      = 15'h7FFF;
   localparam logic [7:0]  DEF_ADDR_IN  = 8'd64;
   localparam logic [7:0]  DEF_ADDR_OUT = 8'd66;

endpackage

// File: rtl/flt2int_decode.sv
// -----------------------------------------------------------------------------
// flt2int_decode
//   Purely combinational decode of a half-precision operand: unbiases the
//   exponent, forms the mantissa with its hidden bit, and chooses shift
//   direction and count needed to align the binary point to bit 0.
//
// Ports
//   exp_field  in   5  biased exponent field flt[14:10]
//   frac       in  10  fraction field flt[9:0]
//   mant       out 26  {hidden bit, fraction}, zero-extended
//   shift_left out  1  1 = shift left, 0 = shift right
//   n          out  4  number of single-bit shifts (0 on ovf/unf)
//   ovf        out  1  exponent too large, saturate the magnitude
//   unf        out  1  value below 1.0, magnitude is zero
// -----------------------------------------------------------------------------
module flt2int_decode
   import flt2int_pkg::*;
(
   input  logic [4:0]       exp_field,
   input  logic [9:0]       frac,
   output logic [MAG_W-1:0] mant,
   output logic             shift_left,
   output logic [CNT_W-1:0] n,
   output logic             ovf,
   output logic             unf
);

   localparam logic signed [5:0] E_MAX  = 6'(MAX_E);
   localparam logic signed [5:0] E_FRAC = 6'(FRAC_W);
   localparam logic signed [5:0] E_BIAS = 6'(BIAS);

   logic signed [5:0] e;

   // Exponent field range 0..31 maps to -15..16, which fits 6-bit signed.
   assign e = $signed({1'b0, exp_field}) - E_BIAS;

   // Hidden bit is 1 for every normal number; a zero field gives zero/subnormal.
   assign mant = {{(MAG_W-FRAC_W-1){1'b0}}, |exp_field, frac};

   always_comb begin
      ovf        = 1'b0;
      unf        = 1'b0;
      shift_left = 1'b0;
      n          = '0;
      if (e > E_MAX) begin
         ovf = 1'b1;
      end else if (e[5]) begin
         unf = 1'b1;
      end else if (e >= E_FRAC) begin
         // e is 10..14 here, so the 4-bit difference is exact.
         shift_left = 1'b1;
         n          = e[3:0] - 4'(FRAC_W);
      end else begin
         // e is 0..9 here.
         n          = 4'(FRAC_W) - e[3:0];
      end
   end

endmodule

// File: rtl/flt2int_ctrl.sv
// -----------------------------------------------------------------------------
// flt2int_ctrl
//   Single-shot converter. After each reset release it reads a half-precision
//   operand (MSB at ADDR_IN, LSB at ADDR_IN+1) from data memory, converts it to
//   a 16-bit sign-magnitude integer with truncation toward zero and saturation
//   at 0x7FFF, writes the result (MSB at ADDR_OUT, LSB at ADDR_OUT+1) and then
//   holds done high until reset. The magnitude is aligned by a one-bit-per-cycle
//   shifter, so latency is 5 + n cycles where n is the decoded shift count.
//
// Ports
//   clk          in   1  clock, rising-edge active
//   reset        in   1  asynchronous, active-high; aborts any conversion
//   mem_addr     out  8  data-memory byte address
//   mem_rd_data  in   8  combinational read data for mem_addr
//   mem_wr_data  out  8  write data
//   mem_wr_en    out  1  write strobe, memory captures on rising clk
//   done         out  1  result written
// -----------------------------------------------------------------------------
module flt2int_ctrl
   import flt2int_pkg::*;
#(
   parameter logic [7:0] ADDR_IN  = DEF_ADDR_IN,
   parameter logic [7:0] ADDR_OUT = DEF_ADDR_OUT
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rd_data,
   output logic [7:0] mem_wr_data,
   output logic       mem_wr_en,
   output logic       done
);

   state_t state;
   state_t state_nxt;

   logic [15:0]      flt;
   logic [MAG_W-1:0] mag;
   logic [CNT_W-1:0] n;
   logic             shift_left;

   logic [MAG_W-1:0] dec_mant;
   logic             dec_left;
   logic [CNT_W-1:0] dec_n;
   logic             dec_ovf;
   logic             dec_unf;

   logic [15:0]      result;

   // Initial magnitude loaded at decode: clamp on overflow, clear on underflow.
   function automatic logic [MAG_W-1:0] saturate(
      input logic             ovf,
      input logic             unf,
      input logic [MAG_W-1:0] mant
   );
      if (ovf)
         return {{(MAG_W-15){1'b0}}, SAT_MAG};
      else if (unf)
         return '0;
      else
         return mant;
   endfunction

   // A zero magnitude always packs as +0 so -0.x and -0 never emit 0x8000.
   function automatic logic [15:0] pack_result(
      input logic             sign,
      input logic [MAG_W-1:0] m
   );
      if (m == '0)
         return 16'h0000;
      else
         return {sign, m[14:0]};
   endfunction

   flt2int_decode u_decode (
      .exp_field  (flt[14:10]),
      .frac       (flt[9:0]),
      .mant       (dec_mant),
      .shift_left (dec_left),
      .n          (dec_n),
      .ovf        (dec_ovf),
      .unf        (dec_unf)
   );

   assign result = pack_result(flt[15], mag);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= RD_HI;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         RD_HI:   state_nxt = RD_LO;
         RD_LO:   state_nxt = DECODE;
         DECODE:  state_nxt = (dec_n != '0) ? SHIFT : WR_HI;
         // Leave on the cycle that performs the last shift.
         SHIFT:   state_nxt = (n <= CNT_W'(1)) ? WR_HI : SHIFT;
         WR_HI:   state_nxt = WR_LO;
         WR_LO:   state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = RD_HI;
      endcase
   end

   // Moore outputs; reset forces RD_HI, so outputs clear without a clock.
   always_comb begin
      mem_addr    = ADDR_IN;
      mem_wr_data = 8'h00;
      mem_wr_en   = 1'b0;
      done        = 1'b0;
      case (state)
         RD_HI:  mem_addr = ADDR_IN;
         RD_LO:  mem_addr = ADDR_IN + 8'd1;
         WR_HI: begin
            mem_addr    = ADDR_OUT;
            mem_wr_data = result[15:8];
            mem_wr_en   = 1'b1;
         end
         WR_LO: begin
            mem_addr    = ADDR_OUT + 8'd1;
            mem_wr_data = result[7:0];
            mem_wr_en   = 1'b1;
         end
         DONE:   done = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, decode load and iterative shifter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flt        <= '0;
         mag        <= '0;
         n          <= '0;
         shift_left <= 1'b0;
      end else begin
         case (state)
            RD_HI: flt[15:8] <= mem_rd_data;
            RD_LO: flt[7:0]  <= mem_rd_data;
            DECODE: begin
               mag        <= saturate(dec_ovf, dec_unf, dec_mant);
               n          <= dec_n;
               shift_left <= dec_left;
            end
            SHIFT: begin
               if (n != '0) begin
                  // Right shift drops low bits: truncation toward zero.
                  mag <= shift_left ? (mag << 1) : (mag >> 1);
                  n   <= n - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flt2int_ctrl.sv
module tb_flt2int_ctrl;

   localparam logic [7:0] ADDR_IN  = 8'd64;
   localparam logic [7:0] ADDR_OUT = 8'd66;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] mem_addr;
   logic [7:0] mem_rd_data;
   logic [7:0] mem_wr_data;
   logic       mem_wr_en;
   logic       done;

   logic [7:0] in_hi;
   logic [7:0] in_lo;

   wr_t exp_q[$];
   int  done_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   int edge_cnt = 0;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   // Data memory read port: only the operand bytes matter to the DUT.
   assign mem_rd_data = (mem_addr == ADDR_IN)        ? in_hi :
                        (mem_addr == ADDR_IN + 8'd1) ? in_lo : 8'hA5;

   flt2int_ctrl #(
      .ADDR_IN  (ADDR_IN),
      .ADDR_OUT (ADDR_OUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_data (mem_wr_data),
      .mem_wr_en   (mem_wr_en),
      .done        (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: numeric value of the half float, truncated toward zero,
   // clamped to 32767; latency from how far the binary point must move.
   task automatic model(input logic [15:0] h, output logic [15:0] res, output int n);
      int    ef;
      int    e;
      real   v;
      real   s;
      longint mag;
      ef = int'(h[14:10]);
      e  = ef - 15;
      n  = 0;
      if (ef == 31) begin
         mag = 32767;
      end else if (ef == 0) begin
         mag = 0;
      end else begin
         s = 1.0;
         if (e >= 0) repeat (e) s = s * 2.0;
         else        repeat (-e) s = s / 2.0;
         v = (1024.0 + real'(int'(h[9:0]))) / 1024.0 * s;
         if (v >= 32768.0) mag = 32767;
         else              mag = longint'($floor(v));
         if (e >= 0 && e <= 14) n = (e >= 10) ? (e - 10) : (10 - e);
      end
      if (mag == 0) res = 16'h0000;
      else          res = {h[15], 15'(mag)};
   endtask

   // Edge counter since reset release
   always @(posedge clk) begin
      if (reset) edge_cnt = 0;
      else       edge_cnt = edge_cnt + 1;
   end

   // Monitor: compares every write and the first done edge against the queues
   always @(negedge clk) begin
      wr_t w;
      int  de;
      if (reset) begin
         done_prev = 1'b0;
      end else begin
         if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", {mem_addr, mem_wr_data}, 32'hFFFF_FFFF);
            end else begin
               w = exp_q.pop_front();
               check("wr_addr", 32'(mem_addr), 32'(w.a));
               check("wr_data", 32'(mem_wr_data), 32'(w.d));
            end
         end
         if (done && !done_prev) begin
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'(edge_cnt), 32'hFFFF_FFFF);
            end else begin
               de = done_q.pop_front();
               check("done_edge", 32'(edge_cnt), 32'(de));
            end
         end
         if (!done && done_prev)
            check("done_dropped", 32'(done), 32'd1);
         done_prev = done;
      end
   end

   task automatic enter_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_done",    32'(done),        32'd0);
      check("rst_wr_en",   32'(mem_wr_en),   32'd0);
      check("rst_wr_data", 32'(mem_wr_data), 32'd0);
      check("rst_addr",    32'(mem_addr),    32'(ADDR_IN));
      exp_q.delete();
      done_q.delete();
   endtask

   task automatic load(input logic [15:0] h, input logic [15:0] res, input int n);
      in_hi = h[15:8];
      in_lo = h[7:0];
      exp_q.push_back(wr_t'({ADDR_OUT, res[15:8]}));
      exp_q.push_back(wr_t'({ADDR_OUT + 8'd1, res[7:0]}));
      done_q.push_back(5 + n);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic run_one(input logic [15:0] h, input logic [15:0] res, input int n);
      int k;
      enter_reset();
      load(h, res, n);
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(done), 32'd1);
      repeat (3) @(negedge clk);
      check("done_hold",   32'(done),         32'd1);
      check("writes_left", 32'(exp_q.size()), 32'd0);
   endtask

   // Reset asserted 'edges' rising edges after release, mid-conversion
   task automatic abort_run(input logic [15:0] h, input int edges);
      logic [15:0] r;
      int          n;
      model(h, r, n);
      enter_reset();
      load(h, r, n);
      repeat (edges) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_wr_en",   32'(mem_wr_en),   32'd0);
      check("abort_done",    32'(done),        32'd0);
      check("abort_wr_data", 32'(mem_wr_data), 32'd0);
      exp_q.delete();
      done_q.delete();
   endtask

   initial begin
      logic [15:0] vec_h  [8];
      logic [15:0] vec_r  [8];
      int          vec_n  [8];
      logic [15:0] h;
      logic [15:0] r;
      int          n;

      vec_h = '{16'hC204, 16'hEE10, 16'h77FF, 16'h7C00, 16'hFBFF, 16'h3800, 16'h0001, 16'h8000};
      vec_r = '{16'h8003, 16'h9840, 16'h7FF0, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
      vec_n = '{9,        2,        4,        0,        0,        0,        0,        0};

      reset = 1'b1;
      in_hi = 8'h00;
      in_lo = 8'h00;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 8; i++)
         run_one(vec_h[i], vec_r[i], vec_n[i]);

      // Abort during SHIFT of 0xC204, then convert 0x4A00
      abort_run(16'hC204, 6);
      run_one(16'h4A00, 16'h000C, 7);

      // Abort while in WR_HI of 0xEE10 (state entered at edge 5)
      abort_run(16'hEE10, 5);
      run_one(16'h3C00, 16'h0001, 10);

      for (int i = 0; i < 30; i++) begin
         if (i % 2 == 0)
            h = {1'($urandom_range(0, 1)), 5'($urandom_range(13, 31)), 10'($urandom)};
         else
            h = 16'($urandom);
         model(h, r, n);
         run_one(h, r, n);
      end

      enter_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/flt2int_ctrl.md
FLT2INT_CTRL -- requirements
Module: flt2int_ctrl

Interface
REQ-001 SHALL have parameter ADDR_IN, default 8'd64, meaning data-memory byte address of the input MSB; the input LSB is at ADDR_IN+1.
REQ-002 SHALL have parameter ADDR_OUT, default 8'd66, meaning data-memory byte address of the result MSB; the result LSB is at ADDR_OUT+1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; 1 = hold, 0 = run.
REQ-005 mem_addr  output  8  data-memory byte address.
REQ-006 mem_rd_data  input  8  combinational read data for mem_addr.
REQ-007 mem_wr_data  output  8  write data.
REQ-008 mem_wr_en  output  1  write strobe; memory captures on rising clk while high.
REQ-009 done  output  1  conversion complete, result written.

Function
REQ-010 SHALL run one conversion per reset release: read half-precision operand, convert to sign-magnitude integer, write result, assert done.
REQ-011 FSM states SHALL be RD_HI, RD_LO, DECODE, SHIFT, WR_HI, WR_LO, DONE.
REQ-012 RD_HI: mem_addr=ADDR_IN; latch mem_rd_data into flt[15:8]; go to RD_LO.
REQ-013 RD_LO: mem_addr=ADDR_IN+1; latch into flt[7:0]; go to DECODE.
REQ-014 DECODE: e = flt[14:10]-15 (signed 6-bit); mant = {|flt[14:10], flt[9:0]} into a 26-bit magnitude register.
REQ-015 DECODE: e>14 -> mag=15'h7FFF, n=0; e<0 -> mag=0, n=0; e in 10..14 -> n=e-10, left shifts; e in 0..9 -> n=10-e, right shifts.
REQ-016 DECODE SHALL go to SHIFT when n>0, else WR_HI.
REQ-017 SHIFT SHALL shift the magnitude exactly one bit per cycle in the chosen direction and decrement n; go to WR_HI when n reaches 0.
REQ-018 Right shifts SHALL truncate toward zero; no rounding.
REQ-019 Result = {sign, mag[14:0]}; sign=flt[15] except result SHALL be 16'h0000 when mag==0.
REQ-020 WR_HI: mem_addr=ADDR_OUT, mem_wr_data=result[15:8], mem_wr_en=1.
REQ-021 WR_LO: mem_addr=ADDR_OUT+1, mem_wr_data=result[7:0], mem_wr_en=1.
REQ-022 DONE: done=1, mem_wr_en=0; remain in DONE until reset.
REQ-023 mem_wr_en SHALL be high only in WR_HI and WR_LO, one cycle each.
REQ-024 done SHALL first be high after rising edge 5+n following reset deassertion.
REQ-025 Exponent field 31 (inf/NaN) SHALL be treated as overflow per REQ-015.
REQ-026 Exponent field 0 (zero/subnormal) SHALL yield result 16'h0000.

Reset
REQ-027 While reset=1: state=RD_HI, done=0, mem_wr_en=0, mem_wr_data=0, flt/mag/n cleared, taking effect immediately without waiting for clk.
REQ-028 Reset asserted in any state, including mid-SHIFT or WR_HI, SHALL abort the conversion; the next release restarts from RD_HI.

Structure
REQ-029 Package flt2int_pkg SHALL hold the state enum, BIAS=15, SAT_MAG=15'h7FFF and default addresses 64/66.
REQ-030 Decode of REQ-014/015 (e, mant, direction, n, overflow/underflow flags) SHALL be a combinational sub-module flt2int_decode; sequencing and shifter stay in flt2int_ctrl.

Verification
REQ-031 0xC204 (-1.50390625*2^1) -> 9 right shifts, result 0x8003, done at edge 14.
REQ-032 0xEE10 (-1.515625*2^12) -> 2 left shifts, result 0x9840 (-6208).
REQ-033 0x77FF (e=14) -> result 0x7FF0; 0x7C00 -> 0x7FFF; 0xFBFF -> 0xFFFF; each with n=0 except 0x77FF (n=4).
REQ-034 0x3800 (0.5), 0x0001 (subnormal), 0x8000 -> result 0x0000, done at edge 5 or 5+n as decoded.
REQ-035 Reset pulsed during SHIFT of 0xC204, memory changed to 0x4A00, released -> no write of stale data, result 0x000C (12).
REQ-036 Every run: exactly two writes, at ADDR_OUT then ADDR_OUT+1; done stays high until reset.
